// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider for RV64M DIV/DIVU/REM/REMU.
// Computes one quotient bit per cycle. Divide-by-zero and signed overflow
// finish on a one-cycle fast path. busy/done are decodes of the state register.
module mdu_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] alu_op1,
    input  logic [XLEN-1:0] alu_op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Combinational helpers for operand conditioning and one shift-subtract step
    logic            is_signed;
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_final;
    logic [XLEN-1:0] rem_final;

    // Next-state and datapath: accept in IDLE, iterate in CALC, retire in DONE
    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        // The dividend's sign tells REM which way to negate; unsigned ops never negate.
        is_signed = ~div_op[0];
        op1_neg   = is_signed & alu_op1[XLEN-1];
        op2_neg   = is_signed & alu_op2[XLEN-1];
        mag1      = op1_neg ? (~alu_op1 + ONE) : alu_op1;
        mag2      = op2_neg ? (~alu_op2 + ONE) : alu_op2;

        // The shifted remainder can be one bit wider than XLEN, so compare at XLEN+1 bits.
        // Because rem < divisor holds between steps, bit XLEN of the difference is its sign.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        fits      = ~trial[XLEN];
        rem_next  = fits ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], fits};
        quo_final = neg_quo_q ? (~quo_next + ONE) : quo_next;
        rem_final = neg_rem_q ? (~rem_next + ONE) : rem_next;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_rem_d  = div_op[1];
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    quo_d     = mag1;
                    dvs_d     = mag2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (alu_op2 == '0) begin
                        result_d = div_op[1] ? alu_op1 : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (is_signed && alu_op1 == MOST_NEG && alu_op2 == ALL_ONES) begin
                        result_d = div_op[1] ? '0 : MOST_NEG;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        result_d = is_rem_q ? rem_final : quo_final;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: directed self-checking bench for mdu_divider (XLEN = 64).
module tb_mdu_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  div_op;
    logic [63:0] alu_op1;
    logic [63:0] alu_op2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks;
    int errors;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    mdu_divider #(.XLEN(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .div_op  (div_op),
        .alu_op1 (alu_op1),
        .alu_op2 (alu_op2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and observe it until done or a 150-cycle bound
    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input bit scramble, output logic [63:0] res, output int done_cyc,
                          output bit busy_seen, output bit overlap);
        start   = 1'b1;
        div_op  = op;
        alu_op1 = a;
        alu_op2 = b;
        step();
        start     = 1'b0;
        done_cyc  = -1;
        busy_seen = 1'b0;
        overlap   = 1'b0;
        res       = 'x;
        for (int c = 1; c <= 150 && done_cyc < 0; c++) begin
            if (busy) busy_seen = 1'b1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                done_cyc = c;
                res      = result;
            end
            if (scramble) begin
                alu_op1 = {$urandom, $urandom};
                alu_op2 = {$urandom, $urandom};
            end
            step();
        end
    endtask

    // Reset state of all outputs
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_flags busy/done got=%b exp=00", {busy, done});
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_result got=%h exp=%h", result, 64'd0);
        end
        rst = 1'b0;
        step();
    endtask

    // Unsigned quotient/remainder including latency and extremes
    task automatic test_unsigned();
        logic [63:0] r;
        int          dc;
        bit          bs, ov;
        run_op(OP_DIVU, 64'd100, 64'd7, 1'b0, r, dc, bs, ov);
        checks++;
        if (dc !== 65) begin
            errors++;
            $display("[TB] FAIL divu_100_7 done_cycle got=%0d exp=65", dc);
        end
        checks++;
        if (r !== 64'd14) begin
            errors++;
            $display("[TB] FAIL divu_100_7 result got=%h exp=%h", r, 64'd14);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu_100_7 busy_done_overlap got=%b exp=0", ov);
        end
        run_op(OP_REMU, 64'd100, 64'd7, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'd2) begin
            errors++;
            $display("[TB] FAIL remu_100_7 result got=%h exp=%h", r, 64'd2);
        end
        run_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL divu_max_1 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        run_op(OP_DIVU, 64'd5, 64'd9, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'd0) begin
            errors++;
            $display("[TB] FAIL divu_5_9 result got=%h exp=%h", r, 64'd0);
        end
        run_op(OP_REMU, 64'd5, 64'd9, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'd5) begin
            errors++;
            $display("[TB] FAIL remu_5_9 result got=%h exp=%h", r, 64'd5);
        end
    endtask

    // Signed sign handling for quotient and remainder
    task automatic test_signed();
        logic [63:0] r;
        int          dc;
        bit          bs, ov;
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL div_m7_2 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL rem_m7_2 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        run_op(OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'd1) begin
            errors++;
            $display("[TB] FAIL rem_7_m2 result got=%h exp=%h", r, 64'd1);
        end
        run_op(OP_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL div_7_m2 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFD);
        end
    endtask

    // Divide by zero takes the fast path
    task automatic test_div_zero();
        logic [63:0] r;
        int          dc;
        bit          bs, ov;
        run_op(OP_DIVU, 64'h1234, 64'd0, 1'b0, r, dc, bs, ov);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("[TB] FAIL divu_by0 done_cycle got=%0d exp=1", dc);
        end
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL divu_by0 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checks++;
        if (bs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu_by0 busy_seen got=%b exp=0", bs);
        end
        run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            errors++;
            $display("[TB] FAIL rem_by0 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFB);
        end
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL div_by0 result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    // Signed overflow takes the fast path
    task automatic test_overflow();
        logic [63:0] r;
        int          dc;
        bit          bs, ov;
        run_op(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, dc, bs, ov);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("[TB] FAIL div_ovf done_cycle got=%0d exp=1", dc);
        end
        checks++;
        if (r !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("[TB] FAIL div_ovf result got=%h exp=%h", r, 64'h8000_0000_0000_0000);
        end
        run_op(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, dc, bs, ov);
        checks++;
        if (r !== 64'd0) begin
            errors++;
            $display("[TB] FAIL rem_ovf result got=%h exp=%h", r, 64'd0);
        end
        run_op(OP_DIVU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, dc, bs, ov);
        checks++;
        if (dc !== 65 || r !== 64'd0) begin
            errors++;
            $display("[TB] FAIL divu_msb_max got=%h cyc=%0d exp=0 cyc=65", r, dc);
        end
    endtask

    // A second start in CALC is ignored; operand changes in CALC are harmless
    task automatic test_back_to_back();
        int          done_count;
        int          first_cyc;
        logic [63:0] r;
        start   = 1'b1;
        div_op  = OP_DIVU;
        alu_op1 = 64'd1000;
        alu_op2 = 64'd10;
        step();
        start      = 1'b0;
        done_count = 0;
        first_cyc  = -1;
        r          = 'x;
        for (int c = 1; c <= 75; c++) begin
            if (done) begin
                done_count++;
                if (first_cyc < 0) begin
                    first_cyc = c;
                    r         = result;
                end
            end
            if (c == 3) begin
                start   = 1'b1;
                div_op  = OP_DIVU;
                alu_op1 = 64'd5;
                alu_op2 = 64'd0;
            end else begin
                start   = 1'b0;
                alu_op1 = {$urandom, $urandom};
                alu_op2 = {$urandom, $urandom};
            end
            step();
        end
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("[TB] FAIL b2b done_count got=%0d exp=1", done_count);
        end
        checks++;
        if (first_cyc !== 65) begin
            errors++;
            $display("[TB] FAIL b2b done_cycle got=%0d exp=65", first_cyc);
        end
        checks++;
        if (r !== 64'd100) begin
            errors++;
            $display("[TB] FAIL b2b result got=%h exp=%h", r, 64'd100);
        end
        checks++;
        if (busy !== 1'b0 || result !== 64'd100) begin
            errors++;
            $display("[TB] FAIL b2b idle_after got busy=%b result=%h exp busy=0 result=%h", busy, result, 64'd100);
        end
    endtask

    // Flush in CALC abandons the op, keeps result, and a new op runs cleanly
    task automatic test_flush();
        logic [63:0] r;
        int          dc;
        bit          bs, ov;
        start   = 1'b1;
        div_op  = OP_DIV;
        alu_op1 = 64'hFFFF_FFFF_FFFF_FF9C;
        alu_op2 = 64'd7;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_flags busy/done got=%b exp=00", {busy, done});
        end
        checks++;
        if (result !== 64'd100) begin
            errors++;
            $display("[TB] FAIL flush_result_hold got=%h exp=%h", result, 64'd100);
        end
        run_op(OP_DIVU, 64'd77, 64'd7, 1'b1, r, dc, bs, ov);
        checks++;
        if (dc !== 65 || r !== 64'd11) begin
            errors++;
            $display("[TB] FAIL flush_then_new got=%h cyc=%0d exp=%h cyc=65", r, dc, 64'd11);
        end
    endtask

    // Reset mid-CALC clears every output on the next cycle
    task automatic test_reset_mid();
        start   = 1'b1;
        div_op  = OP_DIVU;
        alu_op1 = 64'd999;
        alu_op2 = 64'd3;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || result !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid got busy=%b done=%b result=%h exp all zero", busy, done, result);
        end
        for (int c = 0; c < 70; c++) begin
            if (busy || done) begin
                checks++;
                errors++;
                $display("[TB] FAIL reset_mid_resumed at cycle %0d busy=%b done=%b exp 0", c, busy, done);
                break;
            end
            step();
        end
    endtask

    // Simultaneous start and flush in IDLE accepts nothing
    task automatic test_start_flush_idle();
        bit activity;
        start   = 1'b1;
        flush   = 1'b1;
        div_op  = OP_DIVU;
        alu_op1 = 64'h1234;
        alu_op2 = 64'd0;
        step();
        start    = 1'b0;
        flush    = 1'b0;
        activity = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (busy || done) activity = 1'b1;
            step();
        end
        checks++;
        if (activity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_flush_idle activity got=%b exp=0", activity);
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("[TB] FAIL start_flush_idle result got=%h exp=%h", result, 64'd0);
        end
    endtask

    // Scenario sequence
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        div_op  = 2'b00;
        alu_op1 = '0;
        alu_op2 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_start_flush_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
